// File: rtl/axi_rd_pkg.sv
// Shared types and constants for the AXI4 read-port arbiter.
// Holds the controller state encoding, AXI burst/response codes and the ARSIZE helper.
package axi_rd_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam logic [1:0] RRESP_OKAY   = 2'b00;
    localparam logic [1:0] RRESP_SLVERR = 2'b10;
    localparam logic [1:0] RRESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    // ARSIZE encodes bytes-per-beat as a power of two: 64-bit data -> 3.
    function automatic logic [2:0] arsize_of(input int data_w);
        logic [2:0] size;
        size = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if ((8 << i) == data_w) size = 3'(i);
        end
        return size;
    endfunction

endpackage

// File: rtl/axi_rd_arbiter_rr_picker.sv
// Combinational round-robin selector: first set request strictly after i_last,
// wrapping modulo NUM_REQ, returned both one-hot and as an index.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    logic [IDX_W-1:0] w_pos;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_pos   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_pos = IDX_W'((int'(i_last) + k) % NUM_REQ);
            if (!o_any && i_req[w_pos]) begin
                o_any          = 1'b1;
                o_idx          = w_pos;
                o_grant[w_pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read master among NUM_REQ requesters,
// one outstanding burst at a time, with R beats steered back to the granted requester.
module axi_rd_arbiter
    import axi_rd_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*8-1:0]    req_len,
    output logic [DATA_W-1:0]       rsp_data,
    output logic                    rsp_last,
    output logic [NUM_REQ-1:0]      rsp_valid,
    input  logic [NUM_REQ-1:0]      rsp_ready,
    output logic [ADDR_W-1:0]       M_AXI_ARADDR,
    output logic [7:0]              M_AXI_ARLEN,
    output logic [2:0]              M_AXI_ARSIZE,
    output logic [1:0]              M_AXI_ARBURST,
    output logic                    M_AXI_ARID,
    output logic                    M_AXI_ARVALID,
    input  logic                    M_AXI_ARREADY,
    input  logic [DATA_W-1:0]       M_AXI_RDATA,
    input  logic [1:0]              M_AXI_RRESP,
    input  logic                    M_AXI_RLAST,
    input  logic                    M_AXI_RVALID,
    output logic                    M_AXI_RREADY,
    output logic                    busy_out,
    output logic                    err_out
);

    localparam int         IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [2:0] ARSIZE_C = arsize_of(DATA_W);

    state_t           r_state;
    state_t           w_next;
    logic [IDX_W-1:0] r_grant;
    logic [IDX_W-1:0] r_last_grant;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]       r_len;
    logic [8:0]       r_cnt;
    logic             r_err;

    logic [NUM_REQ-1:0] w_pick;
    logic [IDX_W-1:0]   w_pick_idx;
    logic               w_pick_any;
    logic               w_accept;
    logic               w_r_hs;
    logic               w_err_now;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .i_req   (req_valid),
        .i_last  (r_last_grant),
        .o_grant (w_pick),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    assign M_AXI_ARADDR  = r_addr;
    assign M_AXI_ARLEN   = r_len;
    assign M_AXI_ARSIZE  = ARSIZE_C;
    assign M_AXI_ARBURST = AXI_BURST_INCR;
    assign M_AXI_ARID    = 1'b0;
    assign rsp_data      = M_AXI_RDATA;
    assign rsp_last      = M_AXI_RLAST;
    assign busy_out      = (r_state != IDLE);
    assign err_out       = r_err;

    // Handshake-facing outputs are gated by ARESETN so nothing is offered while reset is held.
    always_comb begin
        w_next        = r_state;
        req_ready     = '0;
        rsp_valid     = '0;
        M_AXI_ARVALID = 1'b0;
        M_AXI_RREADY  = 1'b0;
        w_accept      = 1'b0;
        w_r_hs        = 1'b0;
        w_err_now     = 1'b0;
        case (r_state)
            IDLE: begin
                if (ARESETN && w_pick_any) begin
                    req_ready = w_pick;
                    w_accept  = 1'b1;
                    w_next    = ADDR;
                end
            end
            ADDR: begin
                M_AXI_ARVALID = ARESETN;
                if (M_AXI_ARREADY) w_next = DATA;
            end
            DATA: begin
                if (ARESETN) begin
                    M_AXI_RREADY       = rsp_ready[r_grant];
                    rsp_valid[r_grant] = M_AXI_RVALID;
                end
                w_r_hs = M_AXI_RVALID && M_AXI_RREADY;
                // r_cnt is the index of the current beat; the final one must equal ARLEN.
                if (w_r_hs) begin
                    w_err_now = (M_AXI_RRESP != RRESP_OKAY) ||
                                ( M_AXI_RLAST && (r_cnt != {1'b0, r_len})) ||
                                (!M_AXI_RLAST && (r_cnt >= {1'b0, r_len}));
                    if (M_AXI_RLAST) w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_last_grant <= IDX_W'(NUM_REQ - 1);
            r_cnt        <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_grant      <= w_pick_idx;
                r_last_grant <= w_pick_idx;
                r_cnt        <= '0;
            end else if (w_r_hs) begin
                r_cnt <= r_cnt + 9'd1;
            end
            if (w_err_now) r_err <= 1'b1;
        end
    end

    always_ff @(posedge ACLK) begin
        if (w_accept) begin
            r_addr <= req_addr[int'(w_pick_idx)*ADDR_W +: ADDR_W];
            r_len  <= req_len[int'(w_pick_idx)*8 +: 8];
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: a bench-side AXI slave serves bursts while a
// round-robin reference model predicts grants, lengths and the error flag.
`timescale 1ns/1ps
module tb_axi_rd_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 64;

    logic              ACLK = 1'b0;
    logic              ARESETN;
    logic [N-1:0]      req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N*AW-1:0]   req_addr;
    logic [N*8-1:0]    req_len;
    logic [DW-1:0]     rsp_data, RDATA;
    logic              rsp_last;
    logic [AW-1:0]     ARADDR;
    logic [7:0]        ARLEN;
    logic [2:0]        ARSIZE;
    logic [1:0]        ARBURST, RRESP;
    logic              ARID, ARVALID, ARREADY, RLAST, RVALID, RREADY, busy_out, err_out;

    int checks = 0;
    int errors = 0;
    int m_last;

    always #5 ACLK = ~ACLK;

    axi_rd_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
        .rsp_data(rsp_data), .rsp_last(rsp_last), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .M_AXI_ARADDR(ARADDR), .M_AXI_ARLEN(ARLEN), .M_AXI_ARSIZE(ARSIZE),
        .M_AXI_ARBURST(ARBURST), .M_AXI_ARID(ARID), .M_AXI_ARVALID(ARVALID),
        .M_AXI_ARREADY(ARREADY), .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP),
        .M_AXI_RLAST(RLAST), .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY),
        .busy_out(busy_out), .err_out(err_out)
    );

    // Reference rule: first requester after the previous winner, wrapping around.
    function automatic int rr_expect(input logic [N-1:0] m, input int last);
        for (int k = 1; k <= N; k++) begin
            if (m[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic tick;
        @(posedge ACLK);
        #1;
    endtask

    task automatic idle_inputs;
        req_valid = '0;
        rsp_ready = '0;
        ARREADY   = 1'b0;
        RVALID    = 1'b0;
        RLAST     = 1'b0;
        RRESP     = 2'b00;
        RDATA     = '0;
    endtask

    task automatic do_reset;
        idle_inputs();
        ARESETN = 1'b0;
        tick();
        tick();
        ARESETN = 1'b1;
        m_last  = N - 1;
    endtask

    // Acts as requester-side observer and AXI slave for one burst.
    task automatic serve_burst(input int ar_delay, input int rmode, input int last_beat,
                               input int err_beat, input bit drop,
                               output int g, output logic [N-1:0] acc_mask, output int arv_cycles,
                               output logic [AW-1:0] ar_addr, output logic [7:0] ar_len,
                               output bit ar_stable, output int beats, output int bad,
                               output bit to);
        int n;
        int c;
        bit hs;
        bit lst;
        logic [N-1:0] exp_v;
        g = -1; acc_mask = '0; arv_cycles = 0; ar_addr = '0; ar_len = '0;
        ar_stable = 1'b1; beats = 0; bad = 0; to = 1'b0;
        n = 0;
        #1;
        while (req_ready == '0) begin
            if (n >= 100) begin to = 1'b1; return; end
            tick();
            #1;
            n++;
        end
        if (!$onehot(req_ready)) bad++;
        for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
        acc_mask = req_valid;
        tick();
        if (drop) req_valid[g] = 1'b0;
        c = 0;
        ARREADY = (ar_delay == 0);
        #1;
        if (!ARVALID) bad++;
        ar_addr = ARADDR;
        ar_len  = ARLEN;
        while (1) begin
            if (ARVALID) arv_cycles++;
            if (ARADDR !== ar_addr || ARLEN !== ar_len) ar_stable = 1'b0;
            if (ARVALID && ARREADY) break;
            if (c >= 100) begin to = 1'b1; ARREADY = 1'b0; return; end
            tick();
            c++;
            ARREADY = (c >= ar_delay);
            #1;
        end
        tick();
        ARREADY = 1'b0;
        c = 0;
        while (1) begin
            case (rmode)
                0: begin RVALID = 1'b1; rsp_ready = '1; end
                1: begin RVALID = 1'b1; rsp_ready = N'($urandom); rsp_ready[g] = (c % 2 == 0); end
                default: begin
                    RVALID = ($urandom_range(0, 3) != 0);
                    rsp_ready = N'($urandom);
                    rsp_ready[g] = ($urandom_range(0, 3) != 0);
                end
            endcase
            RDATA = {$urandom, $urandom};
            RLAST = (beats == last_beat);
            RRESP = (beats == err_beat) ? 2'b10 : 2'b00;
            #1;
            exp_v = '0;
            if (RVALID) exp_v[g] = 1'b1;
            if (c == 0 && ARVALID) bad++;
            if (RREADY !== rsp_ready[g]) bad++;
            if (rsp_valid !== exp_v) bad++;
            if (rsp_data !== RDATA || rsp_last !== RLAST) bad++;
            hs  = RVALID && RREADY;
            lst = RLAST;
            if (c >= 300) begin to = 1'b1; break; end
            tick();
            c++;
            if (hs) begin
                beats++;
                if (lst) break;
            end
        end
        RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00; rsp_ready = '0;
    endtask

    task automatic test_reset;
        idle_inputs();
        ARESETN   = 1'b0;
        req_valid = '1;
        ARREADY   = 1'b1;
        RVALID    = 1'b1;
        rsp_ready = '1;
        tick();
        tick();
        #1;
        checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy_out); end
        checks++; if (ARVALID !== 1'b0) begin errors++; $display("FAIL reset_arvalid got %0b want 0", ARVALID); end
        checks++; if (RREADY !== 1'b0) begin errors++; $display("FAIL reset_rready got %0b want 0", RREADY); end
        checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL reset_rsp_valid got %0b want 0", rsp_valid); end
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready got %0b want 0", req_ready); end
        checks++; if (err_out !== 1'b0) begin errors++; $display("FAIL reset_err got %0b want 0", err_out); end
        tick();
        idle_inputs();
        ARESETN   = 1'b1;
        m_last    = N - 1;
        req_valid = 4'b1010;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL reset_first_priority got %b want 0010", req_ready); end
        req_valid = '0;
        tick();
    endtask

    task automatic test_single_burst;
        int g, arv, beats, bad;
        logic [N-1:0] am;
        logic [AW-1:0] aa;
        logic [7:0] al;
        bit st, to;
        do_reset();
        req_addr[0 +: AW] = 32'h1000_0000;
        req_len[0 +: 8]   = 8'd3;
        req_valid         = 4'b0001;
        serve_burst(0, 0, 3, -1, 1'b1, g, am, arv, aa, al, st, beats, bad, to);
        #1;
        checks++; if (to) begin errors++; $display("FAIL single_timeout got 1 want 0"); end
        checks++; if (g !== 0) begin errors++; $display("FAIL single_grant got %0d want 0", g); end
        checks++; if (arv !== 1) begin errors++; $display("FAIL single_arvalid_cycles got %0d want 1", arv); end
        checks++; if (aa !== 32'h1000_0000) begin errors++; $display("FAIL single_araddr got %h want 10000000", aa); end
        checks++; if (al !== 8'd3) begin errors++; $display("FAIL single_arlen got %0d want 3", al); end
        checks++; if (ARSIZE !== 3'd3) begin errors++; $display("FAIL single_arsize got %0d want 3", ARSIZE); end
        checks++; if (ARBURST !== 2'b01) begin errors++; $display("FAIL single_arburst got %0d want 1", ARBURST); end
        checks++; if (ARID !== 1'b0) begin errors++; $display("FAIL single_arid got %0d want 0", ARID); end
        checks++; if (beats !== 4) begin errors++; $display("FAIL single_beats got %0d want 4", beats); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL single_protocol got %0d want 0", bad); end
        checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL single_busy_after got %0b want 0", busy_out); end
        checks++; if (err_out !== 1'b0) begin errors++; $display("FAIL single_err got %0b want 0", err_out); end
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL single_no_second_pulse got %b want 0", req_ready); end
    endtask

    task automatic test_contention;
        int g, arv, beats, bad, exp;
        int pulses[N];
        logic [N-1:0] am;
        logic [AW-1:0] aa;
        logic [7:0] al;
        bit st, to;
        do_reset();
        for (int i = 0; i < N; i++) begin
            pulses[i] = 0;
            req_addr[i*AW +: AW] = $urandom;
            req_len[i*8 +: 8]    = 8'd0;
        end
        req_valid = '1;
        for (int b = 0; b < 2 * N; b++) begin
            serve_burst($urandom_range(0, 2), 2, 0, -1, 1'b0, g, am, arv, aa, al, st, beats, bad, to);
            exp = rr_expect(am, m_last);
            checks++; if (to || g !== exp || exp !== b % N) begin errors++; $display("FAIL contention_grant burst %0d got %0d want %0d", b, g, b % N); end
            checks++; if (aa !== req_addr[exp*AW +: AW] || beats !== 1 || bad !== 0) begin errors++; $display("FAIL contention_burst %0d got addr %h beats %0d bad %0d want addr %h beats 1 bad 0", b, aa, beats, bad, req_addr[exp*AW +: AW]); end
            m_last = exp;
            if (g >= 0) pulses[g]++;
            #1;
            checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL contention_idle_gap burst %0d got busy %0b want 0", b, busy_out); end
        end
        req_valid = '0;
        for (int i = 0; i < N; i++) begin
            checks++; if (pulses[i] !== 2) begin errors++; $display("FAIL contention_pulses req %0d got %0d want 2", i, pulses[i]); end
        end
        tick();
    endtask

    task automatic test_backpressure;
        int g, arv, beats, bad;
        logic [N-1:0] am;
        logic [AW-1:0] aa;
        logic [7:0] al;
        bit st, to;
        do_reset();
        req_addr[1*AW +: AW] = $urandom;
        req_len[1*8 +: 8]    = 8'd1;
        req_valid            = 4'b0010;
        serve_burst(5, 1, 1, -1, 1'b1, g, am, arv, aa, al, st, beats, bad, to);
        checks++; if (to || g !== 1) begin errors++; $display("FAIL bp_grant got %0d want 1", g); end
        checks++; if (arv !== 6) begin errors++; $display("FAIL bp_arvalid_cycles got %0d want 6", arv); end
        checks++; if (!st || aa !== req_addr[1*AW +: AW]) begin errors++; $display("FAIL bp_araddr got %h stable %0b want %h stable 1", aa, st, req_addr[1*AW +: AW]); end
        checks++; if (beats !== 2) begin errors++; $display("FAIL bp_beats got %0d want 2", beats); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL bp_rready_mirror got %0d want 0", bad); end
        checks++; if (err_out !== 1'b0) begin errors++; $display("FAIL bp_err got %0b want 0", err_out); end
    endtask

    task automatic test_errors;
        int g, arv, beats, bad;
        logic [N-1:0] am;
        logic [AW-1:0] aa;
        logic [7:0] al;
        bit st, to;
        do_reset();
        req_len[0 +: 8] = 8'd3;
        req_valid       = 4'b0001;
        serve_burst(0, 0, 3, 1, 1'b1, g, am, arv, aa, al, st, beats, bad, to);
        #1;
        checks++; if (err_out !== 1'b1) begin errors++; $display("FAIL err_rresp got %0b want 1", err_out); end
        tick(); tick(); tick();
        checks++; if (err_out !== 1'b1) begin errors++; $display("FAIL err_sticky got %0b want 1", err_out); end
        do_reset();
        #1;
        checks++; if (err_out !== 1'b0) begin errors++; $display("FAIL err_cleared got %0b want 0", err_out); end
        req_len[0 +: 8] = 8'd3;
        req_valid       = 4'b0001;
        serve_burst(0, 0, 1, -1, 1'b1, g, am, arv, aa, al, st, beats, bad, to);
        #1;
        checks++; if (to || beats !== 2 || busy_out !== 1'b0) begin errors++; $display("FAIL err_early_last got beats %0d busy %0b want beats 2 busy 0", beats, busy_out); end
        checks++; if (err_out !== 1'b1) begin errors++; $display("FAIL err_early_last_flag got %0b want 1", err_out); end
        do_reset();
        req_len[0 +: 8] = 8'd1;
        req_valid       = 4'b0001;
        serve_burst(0, 0, 3, -1, 1'b1, g, am, arv, aa, al, st, beats, bad, to);
        #1;
        checks++; if (to || beats !== 4 || err_out !== 1'b1) begin errors++; $display("FAIL err_overrun got beats %0d err %0b want beats 4 err 1", beats, err_out); end
    endtask

    task automatic test_reset_mid_burst;
        int n, g, arv, beats, bad;
        logic [N-1:0] am;
        logic [AW-1:0] aa;
        logic [7:0] al;
        bit st, to;
        do_reset();
        req_addr[0 +: AW] = $urandom;
        req_len[0 +: 8]   = 8'd7;
        req_valid         = 4'b0001;
        n = 0;
        #1;
        while (req_ready == '0 && n < 20) begin tick(); #1; n++; end
        tick();
        req_valid = '0;
        ARREADY   = 1'b1;
        tick();
        ARREADY   = 1'b0;
        RVALID    = 1'b1;
        rsp_ready = '1;
        tick();
        tick();
        #1;
        checks++; if (busy_out !== 1'b1 || rsp_valid !== 4'b0001) begin errors++; $display("FAIL midrst_in_data got busy %0b rsp_valid %b want 1 0001", busy_out, rsp_valid); end
        ARESETN = 1'b0;
        #1;
        checks++; if (RREADY !== 1'b0 || rsp_valid !== '0) begin errors++; $display("FAIL midrst_gate got rready %0b rsp_valid %b want 0 0000", RREADY, rsp_valid); end
        tick();
        #1;
        checks++; if (ARVALID !== 1'b0 || busy_out !== 1'b0 || RREADY !== 1'b0 || rsp_valid !== '0) begin errors++; $display("FAIL midrst_outputs got arv %0b busy %0b rready %0b rsp_valid %b want all 0", ARVALID, busy_out, RREADY, rsp_valid); end
        tick();
        ARESETN   = 1'b1;
        m_last    = N - 1;
        RVALID    = 1'b0;
        rsp_ready = '0;
        req_len[0 +: 8] = 8'd0;
        req_valid = 4'b0011;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL midrst_first_grant got %b want 0001", req_ready); end
        serve_burst(0, 0, 0, -1, 1'b1, g, am, arv, aa, al, st, beats, bad, to);
        req_valid = '0;
        checks++; if (to || g !== 0 || beats !== 1 || bad !== 0) begin errors++; $display("FAIL midrst_burst got g %0d beats %0d bad %0d want 0 1 0", g, beats, bad); end
        tick();
    endtask

    task automatic test_random;
        int g, arv, beats, bad, exp, lb;
        logic [N-1:0] am;
        logic [AW-1:0] aa;
        logic [7:0] al;
        bit st, to;
        do_reset();
        for (int b = 0; b < 20; b++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && ($urandom_range(0, 1) == 1 || (i == N - 1 && req_valid == '0))) begin
                    req_valid[i]         = 1'b1;
                    req_addr[i*AW +: AW] = $urandom;
                    req_len[i*8 +: 8]    = 8'($urandom_range(0, 5));
                end
            end
            exp = rr_expect(req_valid, m_last);
            lb  = int'(req_len[exp*8 +: 8]);
            serve_burst($urandom_range(0, 3), 2, lb, -1, 1'b1, g, am, arv, aa, al, st, beats, bad, to);
            checks++; if (to || g !== exp) begin errors++; $display("FAIL random_grant burst %0d got %0d want %0d", b, g, exp); end
            checks++; if (aa !== req_addr[exp*AW +: AW] || al !== req_len[exp*8 +: 8] || beats !== lb + 1 || bad !== 0) begin errors++; $display("FAIL random_burst %0d got addr %h len %0d beats %0d bad %0d want addr %h len %0d beats %0d bad 0", b, aa, al, beats, bad, req_addr[exp*AW +: AW], lb, lb + 1); end
            m_last = exp;
        end
        #1;
        checks++; if (err_out !== 1'b0) begin errors++; $display("FAIL random_err got %0b want 0", err_out); end
        req_valid = '0;
        tick();
    endtask

    initial begin
        idle_inputs();
        ARESETN  = 1'b0;
        req_addr = '0;
        req_len  = '0;
        m_last   = N - 1;
        test_reset();
        test_single_burst();
        test_contention();
        test_backpressure();
        test_errors();
        test_reset_mid_burst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
